// File: rtl/debug_log_reader_pkg.sv
// rtl/debug_log_reader_pkg.sv - shared constants for the debug log reader
//
// Purpose: single source for the default log depth, the host register
// address map (byte offsets) and the read-side FSM state encoding.
// Ports: none (package).

package debug_log_reader_pkg;

  // log2 of the number of buffered records; every reader defaults to this.
  localparam int LOG_LOG_DEPTH = 14;

  // Host register map, byte offsets on the OCL read channel.
  localparam logic [7:0] LOG_REG_SIZE     = 8'h00;
  localparam logic [7:0] LOG_REG_DROPS    = 8'h04;
  localparam logic [7:0] LOG_REG_DATA     = 8'h08;
  localparam logic [7:0] LOG_REG_CAPACITY = 8'h0C;
  localparam logic [7:0] LOG_REG_WORD_IDX = 8'h10;

  // Read-side FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/debug_log_reader_if.sv
// rtl/debug_log_reader_if.sv - host read channel (AR/R) bundle
//
// Purpose: groups the AXI-Lite style read address / read data handshake.
// Ports:
//   arvalid, araddr[7:0]  host -> reader  read request, byte address
//   arready               reader -> host  request accepted
//   rvalid, rdata[31:0]   reader -> host  read response
//   rready                host -> reader  response accepted
// Modports: master (host side), slave (reader side).

interface debug_log_reader_if;
  logic        arvalid;
  logic [7:0]  araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rready;

  modport master (output arvalid, araddr, rready, input arready, rvalid, rdata);
  modport slave  (input arvalid, araddr, rready, output arready, rvalid, rdata);
endinterface

// File: rtl/debug_log_reader_log_ram.sv
// rtl/debug_log_reader_log_ram.sv - simple dual-port record RAM
//
// Purpose: one write port, one registered read port, no reset, so that
// synthesis maps it onto block/ultra RAM.
// Ports:
//   clk                  clock
//   we, waddr, wdata     write port
//   re, raddr            read enable/address; rdata valid the next cycle
//   rdata                registered read data, held while re is low

module log_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/debug_log_reader.sv
// rtl/debug_log_reader.sv - host read end of an on-chip debug log buffer
//
// Purpose: loggers push fixed-width records into a circular buffer; the host
// drains them as 32-bit words and can read occupancy, drop count, capacity
// and the current word index.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   log_valid, log_data  record push (no back-pressure; dropped when full)
//   ocl                  host read channel (debug_log_reader_if.slave)

module debug_log_reader
  import debug_log_reader_pkg::*;
#(
  parameter int LOG_DEPTH = LOG_LOG_DEPTH,
  parameter int WIDTH     = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             log_valid,
  input  logic [WIDTH-1:0] log_data,
  debug_log_reader_if.slave ocl
);

  localparam int N_WORDS = WIDTH / 32;
  localparam int DEPTH   = 1 << LOG_DEPTH;
  localparam int CNT_W   = LOG_DEPTH + 1;
  localparam int WI_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [WI_W-1:0]  LAST_WORD  = WI_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [1:0]               state;
  logic [5:0]               addr_q;
  logic [LOG_DEPTH-1:0]     wr_ptr;
  logic [LOG_DEPTH-1:0]     rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [WI_W-1:0]          word_idx;
  logic [31:0]              drops;
  logic [31:0]              resp_q;
  logic                     resp_hit;
  logic [31:0]              reg_value;
  logic [WIDTH-1:0]         ram_rdata;
  logic [N_WORDS-1:0][31:0] rec_words;
  logic [7:0]               fetch_addr;
  logic                     full;
  logic                     push;
  logic                     r_hs;
  logic                     pop;
  logic                     unused_araddr_lsbs;

  // Byte-lane bits of the address carry no meaning for word registers.
  assign unused_araddr_lsbs = ^ocl.araddr[1:0];

  assign fetch_addr = {addr_q, 2'b00};
  assign full       = (count == FULL_COUNT);
  // Full is judged on the count at the start of the cycle, so a pop in the
  // same cycle never lets a push through.
  assign push       = log_valid && !full;
  assign r_hs       = (state == ST_RESP) && ocl.rready;
  // Only a DATA read that found a record advances the head, and only once
  // its last word has been handed over.
  assign pop        = r_hs && resp_hit && (word_idx == LAST_WORD);
  assign rec_words  = ram_rdata;

  assign ocl.arready = (state == ST_IDLE);
  assign ocl.rvalid  = (state == ST_RESP);
  // The RAM output register is stable through RESP (no read enable), and
  // word_idx only moves at the handshake, so the selected word holds.
  assign ocl.rdata   = (state != ST_RESP) ? 32'h0 :
                       resp_hit           ? rec_words[word_idx] : resp_q;

  log_ram #(
    .ADDR_W (LOG_DEPTH),
    .DATA_W (WIDTH)
  ) u_log_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (log_data),
    .re    (state == ST_FETCH),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_comb begin
    reg_value = 32'h0;
    case (fetch_addr)
      LOG_REG_SIZE:     reg_value = 32'(count);
      LOG_REG_DROPS:    reg_value = drops;
      LOG_REG_CAPACITY: reg_value = 32'(DEPTH);
      LOG_REG_WORD_IDX: reg_value = 32'(word_idx);
      default:          reg_value = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_idx <= '0;
      drops    <= '0;
      resp_q   <= '0;
      resp_hit <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (log_valid && full && (drops != 32'hFFFF_FFFF)) drops <= drops + 32'd1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (r_hs && resp_hit) word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + 1'b1;

      case (state)
        ST_IDLE: begin
          if (ocl.arvalid) begin
            addr_q <= ocl.araddr[7:2];
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          resp_hit <= (fetch_addr == LOG_REG_DATA) && (count != '0);
          resp_q   <= reg_value;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (ocl.rready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_log_reader.sv
// tb/tb_debug_log_reader.sv - self-checking bench for debug_log_reader

module tb_debug_log_reader;
  import debug_log_reader_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         lv [2];
  logic [127:0] ld [2];
  logic         arv [2];
  logic [7:0]   ara [2];
  logic         rrdy [2];
  logic         arready_v [2];
  logic         rvalid_v [2];
  logic [31:0]  rdata_v [2];

  debug_log_reader_if bus0();
  debug_log_reader_if bus1();

  assign bus0.arvalid = arv[0];
  assign bus0.araddr  = ara[0];
  assign bus0.rready  = rrdy[0];
  assign arready_v[0] = bus0.arready;
  assign rvalid_v[0]  = bus0.rvalid;
  assign rdata_v[0]   = bus0.rdata;
  assign bus1.arvalid = arv[1];
  assign bus1.araddr  = ara[1];
  assign bus1.rready  = rrdy[1];
  assign arready_v[1] = bus1.arready;
  assign rvalid_v[1]  = bus1.rvalid;
  assign rdata_v[1]   = bus1.rdata;

  debug_log_reader #(.LOG_DEPTH(14), .WIDTH(128)) dut0 (
    .clk(clk), .rstn(rstn), .log_valid(lv[0]), .log_data(ld[0]), .ocl(bus0));
  debug_log_reader #(.LOG_DEPTH(2), .WIDTH(128)) dut1 (
    .clk(clk), .rstn(rstn), .log_valid(lv[1]), .log_data(ld[1]), .ocl(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of whole records per instance, host word cursor.
  int           cap [2];
  logic [127:0] mbuf [2][16];
  int           mhead [2];
  int           mcnt [2];
  int           mwi [2];
  logic [31:0]  mdrops [2];

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      mhead[d] = 0; mcnt[d] = 0; mwi[d] = 0; mdrops[d] = 32'h0;
    end
  endtask

  // One clock edge: push decided on occupancy before any pop of that edge.
  task automatic model_edge(input int d, input bit push_en, input logic [127:0] pdata, input bit data_hs);
    int sz;
    int tail;
    sz   = mcnt[d];
    tail = (mhead[d] + sz) % 16;
    if (data_hs && sz > 0) begin
      mwi[d]++;
      if (mwi[d] == 4) begin
        mwi[d] = 0;
        mhead[d] = (mhead[d] + 1) % 16;
        mcnt[d]--;
      end
    end
    if (push_en) begin
      if (sz < cap[d]) begin
        mbuf[d][tail] = pdata;
        mcnt[d]++;
      end else if (mdrops[d] != 32'hFFFF_FFFF) begin
        mdrops[d]++;
      end
    end
  endtask

  function automatic logic [31:0] model_reg(input int d, input logic [7:0] a);
    logic [127:0] rec;
    case ({a[7:2], 2'b00})
      8'h00: return 32'(mcnt[d]);
      8'h04: return mdrops[d];
      8'h08: begin
        if (mcnt[d] == 0) return 32'h0;
        rec = mbuf[d][mhead[d]];
        return rec[32*mwi[d] +: 32];
      end
      8'h0C: return 32'(cap[d]);
      8'h10: return 32'(mwi[d]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic push(input int d, input logic [127:0] data);
    @(negedge clk);
    lv[d] = 1'b1;
    ld[d] = data;
    model_edge(d, 1'b1, data, 1'b0);
    @(negedge clk);
    lv[d] = 1'b0;
  endtask

  // One host read; optionally pushes every cycle and holds rready low for
  // `hold` cycles of rvalid.  exp is the model's view when rvalid appears.
  task automatic bus_read(input int d, input logic [7:0] addr, input bit push_all, input int hold,
                          output logic [31:0] got, output logic [31:0] exp);
    int n, acc_at, rv_at, waited;
    bit acc, done, hs, is_data;
    logic [127:0] pd;
    logic [31:0] first;
    is_data = ({addr[7:2], 2'b00} == 8'h08);
    @(negedge clk);
    arv[d] = 1'b1; ara[d] = addr; rrdy[d] = (hold == 0);
    acc = 0; done = 0; n = 0; acc_at = -1; rv_at = -1; waited = 0;
    got = 32'h0; exp = 32'h0; pd = '0; first = 32'h0;
    while (!done && n < 64) begin
      if (push_all) begin
        pd = {$urandom, $urandom, $urandom, $urandom};
        lv[d] = 1'b1; ld[d] = pd;
      end
      if (rvalid_v[d] && rv_at < 0) begin
        rv_at = n; first = rdata_v[d]; exp = model_reg(d, addr);
      end
      if (rvalid_v[d] && !rrdy[d]) begin
        checks++;
        if (rdata_v[d] !== first || arready_v[d] !== 1'b0)
          $display("FAIL hold_stable: rdata %h arready %b, required rdata %h arready 0",
                   rdata_v[d], arready_v[d], first);
        if (rdata_v[d] !== first || arready_v[d] !== 1'b0) errors++;
        waited++;
        if (waited >= hold) rrdy[d] = 1'b1;
      end
      hs = rvalid_v[d] && rrdy[d];
      if (hs) got = rdata_v[d];
      if (arv[d] && arready_v[d]) begin acc = 1; acc_at = n; end
      model_edge(d, push_all, pd, hs && is_data);
      @(negedge clk);
      if (acc) arv[d] = 1'b0;
      if (hs) done = 1;
      n++;
    end
    lv[d] = 1'b0; rrdy[d] = 1'b0; arv[d] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL read_timeout: addr %h no handshake within 64 cycles", addr);
    end else if (rv_at - acc_at != 2) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles, required 2", rv_at - acc_at);
    end
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (arready_v[d] !== 1'b1 || rvalid_v[d] !== 1'b0 || rdata_v[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: arready %b rvalid %b rdata %h, required 1 0 0",
                 d, arready_v[d], rvalid_v[d], rdata_v[d]);
      end
    end
    bus_read(0, 8'h00, 0, 0, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_size: got %h required 0", got); end
    bus_read(0, 8'h04, 0, 0, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_drops: got %h required 0", got); end
    bus_read(0, 8'h0C, 0, 0, got, exp);
    checks++; if (got !== 32'd16384) begin errors++; $display("FAIL capacity14: got %h required 4000", got); end
    bus_read(1, 8'h0C, 0, 0, got, exp);
    checks++; if (got !== 32'd4) begin errors++; $display("FAIL capacity2: got %h required 4", got); end
  endtask

  task automatic test_word_order;
    logic [31:0] got, exp;
    push(0, 128'h00000004_00000003_00000002_00000001);
    push(0, 128'h00000008_00000007_00000006_00000005);
    for (int k = 0; k < 8; k++) begin
      bus_read(0, 8'h08, 0, 0, got, exp);
      checks++;
      if (got !== 32'(k + 1)) begin
        errors++; $display("FAIL word_order[%0d]: got %h required %h", k, got, 32'(k + 1));
      end
      if (k == 3 || k == 7) begin
        bus_read(0, 8'h00, 0, 0, got, exp);
        checks++;
        if (got !== ((k == 3) ? 32'd1 : 32'd0)) begin
          errors++; $display("FAIL size_after_word%0d: got %h required %0d", k + 1, got, (k == 3) ? 1 : 0);
        end
      end
    end
    bus_read(0, 8'h08, 0, 0, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL empty_data: got %h required 0", got); end
    bus_read(0, 8'h10, 0, 0, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL empty_word_idx: got %h required 0", got); end
  endtask

  task automatic test_random;
    logic [31:0] got, exp;
    logic [7:0] a;
    int pick;
    for (int i = 0; i < 30; i++) begin
      pick = $urandom_range(0, 7);
      if (pick < 2 && mcnt[0] < 12) begin
        push(0, {$urandom, $urandom, $urandom, $urandom});
      end else begin
        case (pick)
          2: a = 8'h00;
          3: a = 8'h04;
          4, 5: a = 8'h08;
          6: a = 8'h10;
          default: a = {6'($urandom_range(5, 63)), 2'b00};
        endcase
        a[1:0] = 2'($urandom);
        bus_read(0, a, 0, 0, got, exp);
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL random_read addr %h: got %h required %h", a, got, exp);
        end
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] got, exp;
    logic [127:0] recs [6];
    for (int i = 0; i < 6; i++) begin
      recs[i] = {$urandom, $urandom, $urandom, $urandom};
      push(1, recs[i]);
    end
    bus_read(1, 8'h00, 0, 0, got, exp);
    checks++; if (got !== 32'd4) begin errors++; $display("FAIL overflow_size: got %h required 4", got); end
    bus_read(1, 8'h04, 0, 0, got, exp);
    checks++; if (got !== 32'd2) begin errors++; $display("FAIL overflow_drops: got %h required 2", got); end
    for (int w = 0; w < 16; w++) begin
      bus_read(1, 8'h08, 0, 0, got, exp);
      checks++;
      if (got !== recs[w/4][32*(w%4) +: 32]) begin
        errors++; $display("FAIL overflow_drain[%0d]: got %h required %h", w, got, recs[w/4][32*(w%4) +: 32]);
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] got, exp;
    push(1, {$urandom, $urandom, $urandom, $urandom});
    push(1, {$urandom, $urandom, $urandom, $urandom});
    bus_read(1, 8'h08, 0, 10, got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL hold_data: got %h required %h", got, exp); end
    bus_read(1, 8'h10, 0, 0, got, exp);
    checks++; if (got !== 32'd1) begin errors++; $display("FAIL hold_word_idx: got %h required 1", got); end
    while (mcnt[1] > 0) begin
      bus_read(1, 8'h08, 0, 0, got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL hold_drain: got %h required %h", got, exp); end
    end
  endtask

  task automatic test_concurrent;
    logic [31:0] got, exp;
    for (int i = 0; i < 4; i++) push(1, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 3; i++) bus_read(1, 8'h08, 0, 0, got, exp);
    bus_read(1, 8'h08, 1, 2, got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL concurrent_last_word: got %h required %h", got, exp); end
    push(1, {$urandom, $urandom, $urandom, $urandom});
    bus_read(1, 8'h00, 0, 0, got, exp);
    checks++; if (got !== 32'd4) begin errors++; $display("FAIL concurrent_size: got %h required 4", got); end
    bus_read(1, 8'h04, 0, 0, got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL concurrent_drops: got %h required %h", got, exp); end
    for (int w = 0; w < 16; w++) begin
      bus_read(1, 8'h08, 0, 0, got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL wrap_drain[%0d]: got %h required %h", w, got, exp); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got, exp;
    int n;
    for (int i = 0; i < 3; i++) push(1, {$urandom, $urandom, $urandom, $urandom});
    bus_read(1, 8'h08, 0, 0, got, exp);
    @(negedge clk);
    arv[1] = 1'b1; ara[1] = 8'h08; rrdy[1] = 1'b0;
    n = 0;
    while (rvalid_v[1] !== 1'b1 && n < 20) begin
      if (arready_v[1]) begin @(negedge clk); arv[1] = 1'b0; end
      else @(negedge clk);
      n++;
    end
    arv[1] = 1'b0;
    checks++;
    if (rvalid_v[1] !== 1'b1) begin errors++; $display("FAIL reset_mid_setup: rvalid %b required 1", rvalid_v[1]); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (rvalid_v[1] !== 1'b0 || rdata_v[1] !== 32'h0 || arready_v[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_outputs: rvalid %b rdata %h arready %b, required 0 0 1",
               rvalid_v[1], rdata_v[1], arready_v[1]);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    bus_read(1, 8'h00, 0, 0, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_mid_size: got %h required 0", got); end
    bus_read(1, 8'h10, 0, 0, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_mid_word_idx: got %h required 0", got); end
    bus_read(1, 8'h04, 0, 0, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_mid_drops: got %h required 0", got); end
  endtask

  initial begin
    cap[0] = 16384;
    cap[1] = 4;
    for (int d = 0; d < 2; d++) begin
      lv[d] = 1'b0; ld[d] = '0; arv[d] = 1'b0; ara[d] = 8'h0; rrdy[d] = 1'b0;
    end
    model_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_word_order();
    test_random();
    test_overflow();
    test_hold();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
